// File: rtl/an_code_pkg.sv
// Shared constants, status codes and FSM states for the AN-code (A = 4547) decoders.
// Pure declarations: no latency, no backpressure.
package an_code_pkg;

    localparam int unsigned A      = 4547;
    localparam int unsigned W_BITS = 29;
    localparam int unsigned N_BITS = 16;
    localparam int unsigned R_BITS = 13;

    typedef enum logic [1:0] {
        ST_CLEAN   = 2'b00,
        ST_CORR    = 2'b01,
        ST_UNCORR  = 2'b10,
        ST_OVF     = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIV1   = 3'd1,
        LOOKUP = 3'd2,
        DIV2   = 3'd3,
        DONE   = 3'd4
    } state_e;

    // A quotient that does not fit the message width turns a good result into overflow.
    function automatic status_e apply_ovf(input logic [W_BITS-N_BITS-1:0] q_hi,
                                          input status_e st);
        if ((st == ST_CLEAN || st == ST_CORR) && (|q_hi))
            return ST_OVF;
        return st;
    endfunction

endpackage

// File: rtl/an_syndrome_lut.sv
// Syndrome table: remainder R -> {hit, sign, bit index} for single errors +-2^i, i in 0..28.
// Combinational, zero latency, no backpressure.
module an_syndrome_lut
    import an_code_pkg::*;
(
    input  logic [R_BITS-1:0] r,
    output logic              hit,
    output logic              sign,
    output logic [4:0]        idx
);

    localparam logic [R_BITS:0] A_W = (R_BITS+1)'(A);

    logic [R_BITS:0] p;

    // p walks 2^i mod A; every table entry is a compile-time constant after unrolling.
    always_comb begin
        hit  = 1'b0;
        sign = 1'b0;
        idx  = '0;
        p    = (R_BITS+1)'(1);
        for (int i = 0; i < int'(W_BITS); i++) begin
            if ({1'b0, r} == p) begin
                hit  = 1'b1;
                sign = 1'b0;
                idx  = 5'(i);
            end
            if ({1'b0, r} == A_W - p) begin
                hit  = 1'b1;
                sign = 1'b1;
                idx  = 5'(i);
            end
            p = ((p << 1) >= A_W) ? (p << 1) - A_W : (p << 1);
        end
    end

endmodule

// File: rtl/an_sec_decode_ctrl.sv
// Sequential AN-code single-error corrector sharing one bit-serial restoring divider.
// Result after 31 cycles (clean/uncorrectable) or 60 (corrected); holds result until out_ready, one word in flight.
module an_sec_decode_ctrl
    import an_code_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_BITS-1:0] in_w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_n,
    output logic [1:0]        out_status
);

    localparam logic [R_BITS:0] A_W      = (R_BITS+1)'(A);
    localparam logic [4:0]      CNT_INIT = 5'(W_BITS - 1);

    state_e              state, state_nxt;
    logic [W_BITS-1:0]   w_q;
    logic [W_BITS-1:0]   dvd_q;
    logic [W_BITS-1:0]   quo_q;
    logic [R_BITS-1:0]   rem_q;
    logic [4:0]          cnt_q;
    logic [N_BITS-1:0]   out_n_q;
    status_e             out_status_q;

    logic [R_BITS:0]     work;
    logic                ge;
    logic [R_BITS-1:0]   diff;
    logic [R_BITS-1:0]   rem_nxt;
    logic [W_BITS-1:0]   q_nxt;

    logic                hit, sign;
    logic [4:0]          idx;
    logic [W_BITS:0]     pow2;
    logic [W_BITS:0]     wp;

    logic                load_w, load_wp, step, set_res;
    logic [N_BITS-1:0]   res_n;
    status_e             res_st;

    // The single subtractor of the restoring divider.
    assign work    = {rem_q, dvd_q[W_BITS-1]};
    assign ge      = (work >= A_W);
    assign diff    = R_BITS'(work - A_W);
    assign rem_nxt = ge ? diff : work[R_BITS-1:0];
    assign q_nxt   = {quo_q[W_BITS-2:0], ge};

    an_syndrome_lut u_lut (
        .r    (rem_q),
        .hit  (hit),
        .sign (sign),
        .idx  (idx)
    );

    // W' = W - delta in 30 bits; bit 29 set means negative or >= 2^29.
    assign pow2 = (W_BITS+1)'(1) << idx;
    assign wp   = sign ? ({1'b0, w_q} + pow2) : ({1'b0, w_q} - pow2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_w    = 1'b0;
        load_wp   = 1'b0;
        step      = 1'b0;
        set_res   = 1'b0;
        res_n     = quo_q[N_BITS-1:0];
        res_st    = ST_CLEAN;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load_w    = 1'b1;
                    state_nxt = DIV1;
                end
            end
            DIV1: begin
                step = 1'b1;
                if (cnt_q == '0) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (rem_q == '0) begin
                    set_res   = 1'b1;
                    res_st    = apply_ovf(quo_q[W_BITS-1:N_BITS], ST_CLEAN);
                    state_nxt = DONE;
                end else if (!hit || wp[W_BITS]) begin
                    set_res   = 1'b1;
                    res_st    = ST_UNCORR;
                    state_nxt = DONE;
                end else begin
                    load_wp   = 1'b1;
                    state_nxt = DIV2;
                end
            end
            DIV2: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    set_res   = 1'b1;
                    res_n     = q_nxt[N_BITS-1:0];
                    res_st    = (rem_nxt != '0) ? ST_UNCORR
                                                : apply_ovf(q_nxt[W_BITS-1:N_BITS], ST_CORR);
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q          <= '0;
            dvd_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            out_n_q      <= '0;
            out_status_q <= ST_CLEAN;
        end else begin
            if (load_w) begin
                w_q   <= in_w;
                dvd_q <= in_w;
                quo_q <= '0;
                rem_q <= '0;
                cnt_q <= CNT_INIT;
            end
            if (load_wp) begin
                dvd_q <= wp[W_BITS-1:0];
                quo_q <= '0;
                rem_q <= '0;
                cnt_q <= CNT_INIT;
            end
            if (step) begin
                dvd_q <= {dvd_q[W_BITS-2:0], 1'b0};
                rem_q <= rem_nxt;
                quo_q <= q_nxt;
                cnt_q <= cnt_q - 5'd1;
            end
            if (set_res) begin
                out_n_q      <= res_n;
                out_status_q <= res_st;
            end
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_n      = out_n_q;
    assign out_status = out_status_q;

endmodule

// File: tb/tb_an_sec_decode_ctrl.sv
// Bench for an_sec_decode_ctrl: directed vectors plus random words against an arithmetic reference model.
module tb_an_sec_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] in_w;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_n;
    logic [1:0]  out_status;

    int ncmp  = 0;
    int nfail = 0;

    an_sec_decode_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_w       (in_w),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_n      (out_n),
        .out_status (out_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the received word.
    task automatic model(input longint w, output int en, output int est, output int elat);
        longint q, r, wp, p;
        int found, sgn, bi;
        q = w / 4547; r = w % 4547;
        elat = 31; found = 0; sgn = 0; bi = 0; est = 0;
        if (r != 0) begin
            for (int i = 0; i < 29; i++) begin
                p = (longint'(1) << i) % 4547;
                if (p == r) begin found = 1; sgn = 0; bi = i; end
                else if (4547 - p == r) begin found = 1; sgn = 1; bi = i; end
            end
            if (found == 0) est = 2;
            else begin
                wp = (sgn == 1) ? w + (longint'(1) << bi) : w - (longint'(1) << bi);
                if (wp < 0 || wp >= (longint'(1) << 29)) est = 2;
                else begin
                    elat = 60;
                    q = wp / 4547; r = wp % 4547;
                    est = (r != 0) ? 2 : 1;
                end
            end
        end
        if (est <= 1 && q >= 65536) est = 3;
        en = int'(q & 65535);
    endtask

    task automatic run_word(input logic [28:0] w, input int hold, input string tag,
                            output int got_n, output int got_st, output int got_lat);
        int en, est, elat, cyc, guard;
        model(longint'(w), en, est, elat);
        guard = 0;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        in_valid = 1'b1;
        in_w     = w;
        @(posedge clk); #1;
        cyc = 1;
        // Busy-time noise on the input must be ignored.
        while (!out_valid && cyc < 200) begin
            in_valid = 1'($urandom);
            in_w     = 29'($urandom);
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        got_n = int'(out_n); got_st = int'(out_status); got_lat = cyc;
        check({tag, " latency"}, cyc, elat);
        check({tag, " n"}, out_n, en);
        check({tag, " status"}, out_status, est);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, " hold"}, {out_valid, in_ready, out_n, out_status},
                  {1'b1, 1'b0, 16'(en), 2'(est)});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " after transfer"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int gn, gs, gl, cyc;
        longint w, nn;
        rst = 1'b1; in_valid = 1'b0; in_w = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("reset outputs", {in_ready, out_valid, out_n, out_status}, {1'b1, 1'b0, 16'd0, 2'd0});
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle after reset", {in_ready, out_valid}, 2'b10);

        run_word(29'd4547000, 0, "clean", gn, gs, gl);
        check("clean plan", {16'(gn), 2'(gs), 8'(gl)}, {16'd1000, 2'd0, 8'd31});
        run_word(29'd4547001, 0, "plus1", gn, gs, gl);
        check("plus1 plan", {16'(gn), 2'(gs), 8'(gl)}, {16'd1000, 2'd1, 8'd60});
        run_word(29'd4538808, 2, "minus2^13", gn, gs, gl);
        check("minus2^13 plan", {16'(gn), 2'(gs), 8'(gl)}, {16'd1000, 2'd1, 8'd60});
        run_word(29'd4547003, 0, "nolut", gn, gs, gl);
        check("nolut plan", {16'(gn), 2'(gs), 8'(gl)}, {16'd1000, 2'd2, 8'd31});
        run_word(29'd318290000, 5, "overflow", gn, gs, gl);
        check("overflow plan", {16'(gn), 2'(gs), 8'(gl)}, {16'd4464, 2'd3, 8'd31});
        run_word(29'd3645, 0, "rangefail", gn, gs, gl);
        check("rangefail plan", {16'(gn), 2'(gs), 8'(gl)}, {16'd0, 2'd2, 8'd31});
        run_word(29'd4545, 1, "minus2", gn, gs, gl);
        check("minus2 plan", {16'(gn), 2'(gs), 8'(gl)}, {16'd1, 2'd1, 8'd60});

        // Reset in the middle of a corrected decode drops the word.
        in_valid = 1'b1; in_w = 29'd4547001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 40) begin @(posedge clk); #1; cyc++; end
        rst = 1'b1;
        #1;
        check("mid reset outputs", {out_valid, out_n, out_status}, 19'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("after mid reset", {in_ready, out_valid, out_n, out_status}, {1'b1, 1'b0, 16'd0, 2'd0});
        repeat (30) @(posedge clk);
        #1;
        check("dropped word", {in_ready, out_valid}, 2'b10);
        run_word(29'd4547000, 0, "post reset", gn, gs, gl);
        check("post reset plan", {16'(gn), 2'(gs)}, {16'd1000, 2'd0});

        for (int t = 0; t < 40; t++) begin
            nn = longint'($urandom_range(0, 118000));
            w  = nn * 4547;
            case ($urandom_range(0, 3))
                0: ;
                1: w = w + (longint'(1) << $urandom_range(0, 28));
                2: w = w - (longint'(1) << $urandom_range(0, 28));
                default: w = longint'($urandom_range(0, 32'h1FFF_FFFF));
            endcase
            if (w < 0 || w >= (longint'(1) << 29)) w = w & 64'h1FFF_FFFF;
            run_word(29'(w), $urandom_range(0, 3), $sformatf("rand%0d", t), gn, gs, gl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
